// File: rtl/token_loader.sv
// token_loader: byte-stream front end for the grouper.
// Accepts a valid/ready byte stream, writes it into the grouper input memory
// with separator runs collapsed to a single 0x00, appends the double-zero
// frame terminator, then resets and runs the grouper until it reports done.
module token_loader #(
    parameter int unsigned               ADDR_WIDTH = 4,
    parameter int unsigned               DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]     SEP        = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_own,
    output logic                  grp_rst_n,
    output logic                  grp_cs,
    input  logic                  grp_done,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned WA_W  = ADDR_WIDTH + 1;

    // Highest write address a data byte may take: leaves room for two terminators.
    localparam logic [WA_W-1:0] DATA_LIMIT = WA_W'(DEPTH - 3);
    // Highest write address a separator zero may take: leaves room for one terminator.
    localparam logic [WA_W-1:0] SEP_LIMIT  = WA_W'(DEPTH - 2);

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        TERM = 3'd1,
        CLR  = 3'd2,
        RUN  = 3'd3,
        FIN  = 3'd4
    } state_t;

    state_t          state;
    logic [WA_W-1:0] wa;
    logic            prev_sep;
    logic            last_zero;

    logic            accept;
    logic            is_sep;
    logic            take_data;
    logic            take_sep;

    // Byte classification for the current handshake.
    always_comb begin
        accept    = in_valid & in_ready;
        is_sep    = (in_data == SEP) || (in_data == '0);
        take_data = !is_sep && (wa <= DATA_LIMIT);
        take_sep  = is_sep && !prev_sep && !overflow && (wa <= SEP_LIMIT);
    end

    // Frame FSM with registered memory-port and grouper-control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wa        <= '0;
            prev_sep  <= 1'b1;
            last_zero <= 1'b0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_own   <= 1'b1;
            grp_rst_n <= 1'b1;
            grp_cs    <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;

            case (state)
                LOAD: begin
                    if (accept) begin
                        if (take_data) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wa[ADDR_WIDTH-1:0];
                            mem_wdata <= in_data;
                            wa        <= wa + WA_W'(1);
                            prev_sep  <= 1'b0;
                            last_zero <= 1'b0;
                        end else if (take_sep) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wa[ADDR_WIDTH-1:0];
                            mem_wdata <= '0;
                            wa        <= wa + WA_W'(1);
                            prev_sep  <= 1'b1;
                            last_zero <= 1'b1;
                        end else if (!is_sep) begin
                            overflow <= 1'b1;
                        end

                        if (in_last) begin
                            state    <= TERM;
                            in_ready <= 1'b0;
                        end
                    end
                end

                // One zero per cycle until the buffer ends in two zeros.
                TERM: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wa[ADDR_WIDTH-1:0];
                    mem_wdata <= '0;
                    wa        <= wa + WA_W'(1);
                    last_zero <= 1'b1;
                    if (last_zero) begin
                        state     <= CLR;
                        grp_rst_n <= 1'b0;
                        mem_own   <= 1'b0;
                    end
                end

                CLR: begin
                    state     <= RUN;
                    grp_rst_n <= 1'b1;
                    grp_cs    <= 1'b1;
                end

                RUN: begin
                    if (grp_done) begin
                        state  <= FIN;
                        grp_cs <= 1'b0;
                        done   <= 1'b1;
                    end
                end

                // Re-arm for the next frame.
                FIN: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    mem_own   <= 1'b1;
                    wa        <= '0;
                    prev_sep  <= 1'b1;
                    last_zero <= 1'b0;
                    overflow  <= 1'b0;
                end

                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    mem_own   <= 1'b1;
                    grp_rst_n <= 1'b1;
                    grp_cs    <= 1'b0;
                    wa        <= '0;
                    prev_sep  <= 1'b1;
                    last_zero <= 1'b0;
                    overflow  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_token_loader.sv
// Directed bench for token_loader: frame table plus reset corner sequences.
module tb_token_loader;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_own;
    logic          grp_rst_n;
    logic          grp_cs;
    logic          grp_done;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    token_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SEP       (8'h20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_own  (mem_own),
        .grp_rst_n(grp_rst_n),
        .grp_cs   (grp_cs),
        .grp_done (grp_done),
        .done     (done),
        .overflow (overflow)
    );

    int tests = 0;
    int fails = 0;
    int wr_cnt;
    logic [DW-1:0] mem_model [DEPTH];

    // '_' in a stimulus string stands for an input 0x00 byte.
    typedef struct {
        string name;
        string din;
        string dexp;   // '.' stands for a 0x00 entry
        bit    ovf;
        bit    hold;   // keep in_valid high while the grouper runs
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] in_code(input byte c);
        return (c == 8'h5F) ? 8'h00 : 8'(c);
    endfunction

    function automatic logic [7:0] exp_code(input byte c);
        return (c == 8'h2E) ? 8'h00 : 8'(c);
    endfunction

    // Memory model: captures every write and checks addresses are sequential.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            check("wr_addr", 32'(mem_addr), 32'(wr_cnt));
            mem_model[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    task automatic start_frame();
        wr_cnt = 0;
        for (int k = 0; k < DEPTH; k++) mem_model[k] = 8'hEE;
    endtask

    task automatic send_bytes(input string s, input bit hold);
        for (int i = 0; i < s.len(); i++) begin
            int w;
            @(negedge clk);
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'(1));
            in_valid = 1'b1;
            in_data  = in_code(s[i]);
            in_last  = (i == s.len() - 1);
        end
        @(negedge clk);
        in_last = 1'b0;
        if (hold) in_data = 8'h51;
        else      in_valid = 1'b0;
    endtask

    task automatic finish_frame(input vec_t v);
        int cyc     = 0;
        int rst_lo  = 0;
        int rdy_hi  = 0;
        int run_bad = 0;
        while (!grp_cs && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!grp_rst_n) rst_lo++;
            if (in_ready)   rdy_hi++;
        end
        check({v.name, "_cs_rise"}, 32'(grp_cs), 32'(1));
        check({v.name, "_grp_rst_cycles"}, 32'(rst_lo), 32'(1));
        check({v.name, "_ready_low"}, 32'(rdy_hi), 32'(0));
        check({v.name, "_own_run"}, 32'(mem_own), 32'(0));
        repeat (3) begin
            if (in_ready || !grp_cs || done || !grp_rst_n) run_bad++;
            @(negedge clk);
        end
        check({v.name, "_run_hold"}, 32'(run_bad), 32'(0));
        grp_done = 1'b1;
        @(negedge clk);
        grp_done = 1'b0;
        check({v.name, "_done"}, 32'(done), 32'(1));
        check({v.name, "_overflow"}, 32'(overflow), 32'(v.ovf));
        check({v.name, "_cs_fin"}, 32'(grp_cs), 32'(0));
        check({v.name, "_ready_fin"}, 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        @(negedge clk);
        check({v.name, "_done_pulse"}, 32'(done), 32'(0));
        check({v.name, "_ready_back"}, 32'(in_ready), 32'(1));
        check({v.name, "_own_back"}, 32'(mem_own), 32'(1));
        check({v.name, "_writes"}, 32'(wr_cnt), 32'(v.dexp.len()));
        for (int k = 0; k < v.dexp.len(); k++)
            check($sformatf("%s_mem%0d", v.name, k), 32'(mem_model[k]), 32'(exp_code(v.dexp[k])));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},    32'(mem_we),    32'(0));
        check({tag, "_mem_addr"},  32'(mem_addr),  32'(0));
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        check({tag, "_mem_own"},   32'(mem_own),   32'(1));
        check({tag, "_grp_rst_n"}, 32'(grp_rst_n), 32'(1));
        check({tag, "_grp_cs"},    32'(grp_cs),    32'(0));
        check({tag, "_done"},      32'(done),      32'(0));
        check({tag, "_overflow"},  32'(overflow),  32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t xv;
        int   w;

        vecs[0] = '{"two_tok",    "ab cd",                "ab.cd..",          1'b0, 1'b0};
        vecs[1] = '{"sep_runs",   "  ab  ",               "ab..",             1'b0, 1'b1};
        vecs[2] = '{"only_sep",   " ",                    "..",               1'b0, 1'b0};
        vecs[3] = '{"long20",     "ABCDEFGHIJKLMNOPQRST", "ABCDEFGHIJKLMN..", 1'b1, 1'b0};
        vecs[4] = '{"nul_sep",    "a_b",                  "a.b..",            1'b0, 1'b0};
        vecs[5] = '{"mixed",      "ab   cd_ e",           "ab.cd.e..",        1'b0, 1'b0};
        vecs[6] = '{"sep_at_end", "ABCDEFGHIJKLMN x",     "ABCDEFGHIJKLMN..", 1'b1, 1'b0};
        vecs[7] = '{"ovf_sep",    "ABCDEFGHIJKLMNO ",     "ABCDEFGHIJKLMN..", 1'b1, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        grp_done = 1'b0;
        wr_cnt   = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check_reset_outputs("post_rst");

        for (int i = 0; i < 8; i++) begin
            start_frame();
            send_bytes(vecs[i].din, vecs[i].hold);
            finish_frame(vecs[i]);
        end

        // Reset pulse while the grouper is running.
        start_frame();
        send_bytes("ab", 1'b0);
        w = 0;
        while (!grp_cs && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("midrun_cs", 32'(grp_cs), 32'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_in_ready", 32'(in_ready), 32'(1));

        xv = '{"after_rst", "x", "x..", 1'b0, 1'b0};
        start_frame();
        send_bytes(xv.din, xv.hold);
        finish_frame(xv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
